// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the MIPS31 5-stage pipeline: load-use bubbles, mul/div busy tracking, branch flush.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cycles/flush_count statistics outputs.
module pipeline_hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic [31:0] exe_instr,
  input  logic        exe_GPR_we,
  input  logic [4:0]  exe_GPR_waddr,
  input  logic        branch_taken,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        if_id_flush,
  output logic        id_exe_ena,
  output logic        id_exe_bubble,
  output logic        md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [5:0] idOpcode;
  logic [5:0] idFunct;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idRtype;
  logic       rsRead;
  logic       rtRead;
  logic       exeIsLoad;
  logic       loadUse;
  logic       mdOp;
  logic       hiloOp;
  logic       isDiv;
  logic       mdHazard;
  logic       stall;
  logic [CNT_W-1:0] issueCnt;
  logic       unusedBits;

  assign idOpcode  = id_instr[31:26];
  assign idRs      = id_instr[25:21];
  assign idRt      = id_instr[20:16];
  assign idFunct   = id_instr[5:0];
  assign idRtype   = (idOpcode == OP_RTYPE);
  assign unusedBits = ^{exe_instr[25:0], id_instr[15:6]};

  // Shift-by-immediate R-types and j/jal/lui carry no rs operand; only a few formats read rt.
  assign rsRead = !((idOpcode == OP_J) || (idOpcode == OP_JAL) || (idOpcode == OP_LUI) ||
                    (idRtype && ((idFunct == 6'b000000) || (idFunct == 6'b000010) ||
                                 (idFunct == 6'b000011))));
  assign rtRead = idRtype || (idOpcode == OP_BEQ) || (idOpcode == OP_BNE) || (idOpcode == OP_SW);

  assign exeIsLoad = (exe_instr[31:26] == OP_LW);
  assign loadUse   = exeIsLoad && exe_GPR_we && (exe_GPR_waddr != 5'd0) &&
                     ((rsRead && (idRs == exe_GPR_waddr)) || (rtRead && (idRt == exe_GPR_waddr)));

  assign mdOp     = idRtype && (idFunct[5:2] == 4'b0110);
  assign hiloOp   = idRtype && (idFunct[5:2] == 4'b0100);
  assign isDiv    = idFunct[1];
  assign mdHazard = (state_q == MD_BUSY) && (mdOp || hiloOp);
  assign stall    = loadUse || mdHazard;
  assign issueCnt = isDiv ? DIV_CNT : MULT_CNT;

  always_comb begin
    pc_ena        = 1'b1;
    if_id_ena     = 1'b1;
    id_exe_ena    = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    md_busy       = 1'b0;
    if (!reset) begin
      md_busy = (state_q == MD_BUSY);
      if (stall) begin
        pc_ena        = 1'b0;
        if_id_ena     = 1'b0;
        id_exe_bubble = 1'b1;
      end else begin
        if_id_flush = branch_taken;
      end
    end
  end

  // A latency of one leaves issueCnt at zero, so the unit never reports busy for it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mdOp && !stall && (issueCnt != '0)) begin
          state_d = MD_BUSY;
          cnt_d   = issueCnt;
        end
      end
      MD_BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCycles_q;
  logic [31:0] flushCount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (stall && (stallCycles_q != 32'hFFFF_FFFF)) begin
        stallCycles_q <= stallCycles_q + 32'd1;
      end
      if (if_id_flush && (flushCount_q != 32'hFFFF_FFFF)) begin
        flushCount_q <= flushCount_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stallCycles_q;
  assign flush_count  = flushCount_q;
`endif

endmodule
